// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Purpose:
//   Receives an instruction image as a byte stream from a UART receiver and
//   stores it in an on-chip instruction memory, then serves instruction
//   fetches from it. The image format is a 16-bit big-endian word count N,
//   followed by N words of DATA_W bits, each sent big-endian.
//   Optional feature: define INST_MEM_CHECKSUM_EN to append one checksum byte
//   (XOR of all data bytes) to the image. A wrong checksum rejects the image.
//
// Parameters:
//   DATA_W  instruction word width in bits (multiple of 8)
//   DEPTH   number of instruction words stored
//   ADDR_W  word-index width (2**ADDR_W >= DEPTH)
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   rx_valid      one-cycle strobe, rx_byte valid
//   rx_byte       byte from UART receiver
//   reload        one-cycle pulse, abort and restart loading
//   inst_addr     byte address from PC
//   read_inst     instruction at inst_addr (0 = NOP until image is loaded)
//   load_done     image fully and validly loaded
//   load_err      image rejected
//   busy          loading in progress
//   words_loaded  count of words written during this load
// -----------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              reload,
  input  logic [31:0]       inst_addr,
  output logic [DATA_W-1:0] read_inst,
  output logic              load_done,
  output logic              load_err,
  output logic              busy,
  output logic [15:0]       words_loaded
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  // First byte address past the memory; fetches at or beyond it return NOP.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_READY,
`ifdef INST_MEM_CHECKSUM_EN
    S_CHK,
`endif
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      words_q, words_d;
`ifdef INST_MEM_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  logic [15:0]       len_full;
  logic [15:0]       words_inc;
  logic              data_take;
  logic              mem_we;
  logic [DATA_W-1:0] word_asm;

  logic [DATA_W-1:0] mem [DEPTH];

  assign len_full  = {len_q[15:8], rx_byte};
  assign words_inc = words_q + 16'd1;

  // Word assembly: the previous BPW-1 bytes sit in a shift buffer, so the
  // complete word is available combinationally while the last byte is
  // presented and can be written on that same edge.
  generate
    if (BPW > 1) begin : g_shift
      logic [DATA_W-9:0] buf_q;
      logic [DATA_W-1:0] asm_full;

      assign asm_full = {buf_q, rx_byte};
      assign word_asm = asm_full;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_q <= '0;
        end else if (data_take) begin
          buf_q <= asm_full[DATA_W-9:0];
        end
      end
    end else begin : g_byte
      assign word_asm = rx_byte;
    end
  endgenerate

  // State and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      cnt_q   <= '0;
      words_q <= '0;
`ifdef INST_MEM_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
`ifdef INST_MEM_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    data_take = 1'b0;
    mem_we    = 1'b0;
`ifdef INST_MEM_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    if (reload) begin
      // reload beats a coincident rx_valid: the byte is simply dropped
      state_d = S_LEN_HI;
      cnt_d   = '0;
      words_d = '0;
`ifdef INST_MEM_CHECKSUM_EN
      chk_d   = '0;
`endif
    end else if (rx_valid) begin
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = rx_byte;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = rx_byte;
          if ({1'b0, len_full} > DEPTH_L) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
`ifdef INST_MEM_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_READY;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          data_take = 1'b1;
`ifdef INST_MEM_CHECKSUM_EN
          chk_d = chk_q ^ rx_byte;
`endif
          if (cnt_q == LAST_BYTE) begin
            mem_we  = 1'b1;
            cnt_d   = '0;
            words_d = words_inc;
            if (words_inc == len_q) begin
`ifdef INST_MEM_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_READY;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef INST_MEM_CHECKSUM_EN
        S_CHK: begin
          state_d = (rx_byte == chk_q) ? S_READY : S_ERROR;
        end
`endif
        default: begin
          // READY and ERROR ignore incoming bytes
        end
      endcase
    end
  end

  // Instruction memory: no reset, contents survive reload. The write index
  // is always < DEPTH because N > DEPTH never reaches the DATA state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[words_q[ADDR_W-1:0]] <= word_asm;
    end
  end

  // Outputs
  assign load_done    = (state_q == S_READY);
  assign load_err     = (state_q == S_ERROR);
  assign words_loaded = words_q;

  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_LEN_LO, S_DATA: busy = 1'b1;
`ifdef INST_MEM_CHECKSUM_EN
      S_CHK:            busy = 1'b1;
`endif
      default:          busy = 1'b0;
    endcase
  end

  // Range check uses the full byte address so that high address bits
  // outside the index field cannot alias onto a valid word.
  always_comb begin
    read_inst = '0;
    if (load_done && ({1'b0, inst_addr} < ADDR_LIMIT)) begin
      read_inst = mem[inst_addr[ADDR_W+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              reload = 1'b0;
  logic [31:0]       inst_addr = 32'h0;
  logic [DATA_W-1:0] read_inst;
  logic              load_done;
  logic              load_err;
  logic              busy;
  logic [15:0]       words_loaded;

  inst_mem_loader #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .reload      (reload),
    .inst_addr   (inst_addr),
    .read_inst   (read_inst),
    .load_done   (load_done),
    .load_err    (load_err),
    .busy        (busy),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image plus which entries hold known data.
  logic [31:0] model_mem [DEPTH];
  bit          model_wr  [DEPTH];
  bit          cur_done = 1'b0;
  logic [31:0] img_words [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Sends the first k bytes (k < 0: all) of the image {N, img_words[, xor]},
  // then checks status against what the image rules predict.
  task automatic do_load(input string tag, input int n, input int k);
    logic [7:0] tx[$];
    logic [7:0] x;
    logic [15:0] n16;
    int total, nw;
    bit e_done, e_err, e_busy;
    int e_words;
    x   = 8'h00;
    n16 = 16'(n);
    tx.push_back(n16[15:8]);
    tx.push_back(n16[7:0]);
    if (n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        for (int b = 3; b >= 0; b--) begin
          tx.push_back(img_words[w][8*b +: 8]);
          x = x ^ img_words[w][8*b +: 8];
        end
      end
`ifdef INST_MEM_CHECKSUM_EN
      tx.push_back(x);
`endif
    end
    total = tx.size();
    if (k < 0 || k > total) k = total;
    for (int i = 0; i < k; i++) begin
      if (i == total - 1) check({tag, "_pre_done"}, {31'h0, load_done}, 32'h0);
      send_byte(tx[i]);
    end
    nw = 0;
    if (k >= 2 && n <= DEPTH) begin
      nw = (k - 2) / 4;
      if (nw > n) nw = n;
    end
    for (int w = 0; w < nw; w++) begin
      model_mem[w] = img_words[w];
      model_wr[w]  = 1'b1;
    end
    if (k == total) begin
      check({tag, "_done"}, {31'h0, load_done}, {31'h0, (n <= DEPTH)});
      // trailing bytes must be ignored once READY/ERROR is reached
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      e_done  = (n <= DEPTH);
      e_err   = !e_done;
      e_busy  = 1'b0;
      e_words = e_done ? n : 0;
    end else begin
      e_done  = 1'b0;
      e_err   = (k >= 2 && n > DEPTH);
      e_busy  = (k >= 1) && !e_err;
      e_words = nw;
    end
    check({tag, "_load_done"}, {31'h0, load_done}, {31'h0, e_done});
    check({tag, "_load_err"}, {31'h0, load_err}, {31'h0, e_err});
    check({tag, "_busy"}, {31'h0, busy}, {31'h0, e_busy});
    check({tag, "_words"}, {16'h0, words_loaded}, 32'(e_words));
    cur_done = e_done;
    $display("load %s: N=%0d bytes=%0d/%0d words=%0d done=%0d err=%0d",
             tag, n, k, total, e_words, e_done, e_err);
  endtask

  task automatic check_reads(input string tag);
    logic [31:0] e;
    for (int i = 0; i < 12; i++) begin
      if (!cur_done || model_wr[i]) begin
        @(negedge clk);
        inst_addr = 32'(i * 4 + int'($urandom_range(0, 3)));
        #1;
        e = cur_done ? model_mem[i] : 32'h0;
        check($sformatf("%s_rd%0d", tag, i), read_inst, e);
      end
    end
    @(negedge clk);
    inst_addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
    #1;
    check({tag, "_rd_oob"}, read_inst, 32'h0);
    inst_addr = 32'h0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, total;
    // ---------------- reset state
    repeat (3) @(negedge clk);
    check("rst_load_done", {31'h0, load_done}, 32'h0);
    check("rst_load_err", {31'h0, load_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_words", {16'h0, words_loaded}, 32'h0);
    check("rst_read", read_inst, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- basic two-word image
    img_words = '{32'h20100050, 32'h20110320};
    do_load("basic", 2, 4);
    check("basic_rd_busy", read_inst, 32'h0);
    pulse_reload();
    do_load("basic", 2, -1);
    check_reads("basic");

    // ---------------- oversize word count rejected
    pulse_reload();
    img_words = '{};
    do_load("oversize", 513, -1);
    check_reads("oversize");

    // ---------------- reload with coincident byte mid-word
    pulse_reload();
    img_words = '{32'hAABBCCDD};
    do_load("abort", 1, 4);
    @(negedge clk);
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'hCC;
    @(negedge clk);
    reload   = 1'b0;
    rx_valid = 1'b0;
    check("abort_done", {31'h0, load_done}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_words", {16'h0, words_loaded}, 32'h0);
    do_load("fresh", 1, -1);
    check_reads("fresh");

    // ---------------- asynchronous reset during DATA
    pulse_reload();
    img_words = '{32'h11223344, 32'h55667788};
    do_load("rstmid", 2, 8);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_done", {31'h0, load_done}, 32'h0);
    check("rstmid_busy", {31'h0, busy}, 32'h0);
    check("rstmid_words", {16'h0, words_loaded}, 32'h0);
    check("rstmid_read", read_inst, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    img_words = '{32'hCAFEF00D};
    do_load("after_rst", 1, -1);
    check_reads("after_rst");

`ifdef INST_MEM_CHECKSUM_EN
    // ---------------- checksum good / bad
    pulse_reload();
    img_words = '{32'h12345678};
    do_load("chk_ok", 1, -1);
    check_reads("chk_ok");
    pulse_reload();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h09);
    check("chk_bad_err", {31'h0, load_err}, 32'h1);
    check("chk_bad_read", read_inst, 32'h0);
    cur_done = 1'b0;
`endif

    // ---------------- randomized images, some aborted part way
    for (int it = 0; it < 25; it++) begin
      pulse_reload();
      check("rnd_reload_done", {31'h0, load_done}, 32'h0);
      check("rnd_reload_words", {16'h0, words_loaded}, 32'h0);
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = DEPTH + 1 + int'($urandom_range(0, 60000));
        default: n = int'($urandom_range(1, 10));
      endcase
      img_words = '{};
      if (n <= DEPTH) begin
        for (int w = 0; w < n; w++) img_words.push_back($urandom);
        total = 2 + 4 * n;
`ifdef INST_MEM_CHECKSUM_EN
        total++;
`endif
      end else begin
        total = 2;
      end
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      do_load($sformatf("rnd%0d", it), n, k);
      check_reads($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning number of instruction words stored.
REQ-003 The block SHALL have parameter ADDR_W, default 9, meaning word-index width (2^ADDR_W >= DEPTH).
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_byte valid.
REQ-007 rx_byte  input  8  byte from UART receiver.
REQ-008 reload  input  1  one-cycle pulse, abort and restart loading.
REQ-009 inst_addr  input  32  byte address from PC.
REQ-010 read_inst  output  DATA_W  instruction at inst_addr.
REQ-011 load_done  output  1  image fully and validly loaded.
REQ-012 load_err  output  1  image rejected.
REQ-013 busy  output  1  loading in progress.
REQ-014 words_loaded  output  16  count of words written this load.

Function
REQ-015 The FSM SHALL have states LEN_HI, LEN_LO, DATA, READY, ERROR; plus CHK when checksum is compiled in.
REQ-016 LEN_HI: the first accepted byte SHALL be captured as word-count N[15:8]; the next byte (LEN_LO) as N[7:0].
REQ-017 If N > DEPTH, the FSM SHALL go LEN_LO -> ERROR; if N == 0, LEN_LO -> READY (or CHK); otherwise LEN_LO -> DATA.
REQ-018 DATA: bytes SHALL be assembled big-endian, DATA_W/8 bytes per word; on the edge sampling the last byte, the word SHALL be written to index words_loaded and words_loaded incremented.
REQ-019 The block SHALL leave DATA for READY (or CHK) on the same edge that writes word N-1; load_done SHALL be high the following cycle.
REQ-020 rx_valid SHALL be ignored in READY and ERROR.
REQ-021 read_inst SHALL be combinational: mem[inst_addr[ADDR_W+1:2]] when load_done=1 and that index < DEPTH, else 0 (NOP).
REQ-022 busy SHALL be 1 in LEN_LO, DATA, CHK; 0 in LEN_HI, READY, ERROR.
REQ-023 reload SHALL, from any state, clear load_done, load_err, words_loaded, the byte counter and the checksum accumulator, and enter LEN_HI on the next edge.
REQ-024 reload and rx_valid in the same cycle SHALL discard the byte; reload wins.
REQ-025 Memory contents SHALL persist across reload; only words rewritten change.
REQ-026 load_err SHALL be 1 exactly while in ERROR.

Reset
REQ-027 rst_n low SHALL asynchronously force state LEN_HI, load_done=0, load_err=0, busy=0, words_loaded=0, byte counter 0, checksum 0.
REQ-028 Memory array SHALL NOT be reset; read_inst SHALL be 0 during and after reset until load_done.
REQ-029 Reset asserted mid-load SHALL abandon the partial word without writing it.

Configuration
REQ-030 With macro INST_MEM_CHECKSUM_EN defined, the block SHALL XOR all data bytes; after the last data byte, state CHK SHALL accept one byte: equal -> READY, unequal -> ERROR.
REQ-031 Without INST_MEM_CHECKSUM_EN, CHK and the accumulator SHALL not exist; the last data byte SHALL lead directly to READY.

Verification
REQ-032 Send 00 02, 20 10 00 50, 20 11 03 20 -> load_done=1 one cycle after last byte; inst_addr=0 gives 32'h20100050, inst_addr=4 gives 32'h20110320, words_loaded=2.
REQ-033 Before load_done, inst_addr=0 -> read_inst=0; inst_addr=32'h800 after load -> 0.
REQ-034 Send 02 01 (N=513, DEPTH=512) -> load_err=1, busy=0, subsequent bytes ignored, words_loaded=0.
REQ-035 Mid-word (2 of 4 bytes) pulse reload together with rx_valid -> byte dropped, state LEN_HI, load_done=0; fresh image 00 01 AA BB CC DD loads 32'hAABBCCDD at index 0.
REQ-036 Assert rst_n=0 during DATA -> outputs zero immediately, no partial write; index of the interrupted word keeps its prior value.
REQ-037 With INST_MEM_CHECKSUM_EN: 00 01 12 34 56 78 then checksum 08 -> load_done=1; same image with checksum 09 -> load_err=1, read_inst=0.
